// File: rtl/mdu_if.sv
// Start/busy/done handshake and HI/LO result bus between execute-stage control and the mdu.
interface mdu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [2:0]       op;
    logic [WIDTH-1:0] din1;
    logic [WIDTH-1:0] din2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, flush, op, din1, din2,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, flush, op, din1, din2,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu.sv
// Iterative multiply/divide unit with architectural HI/LO: radix-2 shift-add multiply,
// restoring divide, one bit per cycle, sign fix-up in a final cycle.
module mdu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,
    mdu_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned XW = WIDTH + 1;
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [XW-1:0]    a_q, a_d;
    logic [XW-1:0]    b_q, b_d;
    logic [WIDTH-1:0] din1_q, din1_d;
    logic [XW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] qr_q, qr_d;
    logic             is_div_q, is_div_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Operand magnitudes: signed ops take |x| in WIDTH+1 bits so the most negative value is exact
    logic             is_signed_c;
    logic [XW-1:0]    ext1_c, ext2_c, mag1_c, mag2_c;

    assign is_signed_c = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign ext1_c      = {is_signed_c & bus.din1[WIDTH-1], bus.din1};
    assign ext2_c      = {is_signed_c & bus.din2[WIDTH-1], bus.din2};
    assign mag1_c      = ext1_c[WIDTH] ? (~ext1_c + XW'(1)) : ext1_c;
    assign mag2_c      = ext2_c[WIDTH] ? (~ext2_c + XW'(1)) : ext2_c;

    // One iteration of each algorithm
    logic [XW:0]      sum_c;
    logic [XW-1:0]    trial_c;
    logic [XW:0]      diff_c;
    logic             borrow_c;

    assign sum_c    = {1'b0, acc_q} + (qr_q[0] ? {1'b0, a_q} : '0);
    assign trial_c  = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]};
    assign diff_c   = {1'b0, trial_c} - {1'b0, b_q};
    assign borrow_c = diff_c[XW];

    // Final sign correction
    logic [PW-1:0]    prod_c, prod_neg_c;
    logic [WIDTH-1:0] quo_neg_c, rem_neg_c;
    logic             div_zero_c;

    assign prod_c     = {acc_q[WIDTH-1:0], qr_q};
    assign prod_neg_c = ~prod_c + PW'(1);
    assign quo_neg_c  = ~qr_q + WIDTH'(1);
    assign rem_neg_c  = ~acc_q[WIDTH-1:0] + WIDTH'(1);
    assign div_zero_c = (b_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        din1_d   = din1_q;
        acc_d    = acc_q;
        qr_d     = qr_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            a_d      = mag1_c;
                            b_d      = mag2_c;
                            din1_d   = bus.din1;
                            neg_a_d  = ext1_c[WIDTH];
                            neg_b_d  = ext2_c[WIDTH];
                            is_div_d = bus.op[1];
                            acc_d    = '0;
                            qr_d     = bus.op[1] ? mag1_c[WIDTH-1:0] : mag2_c[WIDTH-1:0];
                            cnt_d    = '0;
                            state_d  = CALC;
                        end
                        OP_MTHI: hi_d = bus.din1;
                        OP_MTLO: lo_d = bus.din1;
                        default: ;
                    endcase
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (is_div_q) begin
                    acc_d = borrow_c ? trial_c : diff_c[XW-1:0];
                    qr_d  = {qr_q[WIDTH-2:0], ~borrow_c};
                end else begin
                    acc_d = sum_c[XW:1];
                    qr_d  = {sum_c[0], qr_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = (neg_a_q ^ neg_b_q) ? prod_neg_c : prod_c;
                end else if (div_zero_c) begin
                    hi_d = din1_q;
                    lo_d = '1;
                end else begin
                    lo_d = (neg_a_q ^ neg_b_q) ? quo_neg_c : qr_q;
                    hi_d = neg_a_q ? rem_neg_c : acc_q[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush abandons the operation and any same-cycle start without touching HI/LO
        if (bus.flush) begin
            state_d = IDLE;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            din1_q   <= '0;
            acc_q    <= '0;
            qr_q     <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            din1_q   <= din1_d;
            acc_q    <= acc_d;
            qr_q     <= qr_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: doc/mdu.md
# mdu

Parametrised iterative multiply/divide unit with architectural HI/LO registers, sitting beside the combinational ALU in the execute stage. It extends the datapath arithmetic with MIPS mult/multu/div/divu/mthi/mtlo, generalised to a WIDTH-bit datapath. It uses a start/busy/done handshake so the pipeline control can stall while an operation runs.

## Interface
- WIDTH, 32: operand, HI and LO width in bits; must be ≥ 4 and even.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Sampled only when busy=0.
- flush  in  1  abort the in-flight operation (exception or pipeline flush).
- op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 no-op.
- din1  in  WIDTH  multiplicand / dividend / mthi-mtlo source.
- din2  in  WIDTH  multiplier / divisor.
- busy  out  1  an iterative operation is in progress.
- done  out  1  one-cycle pulse: HI/LO were just updated by mult/div.
- hi  out  WIDTH  HI register (product high half / remainder).
- lo  out  WIDTH  LO register (product low half / quotient).

## Operation
- States:
  - IDLE: the only state that accepts start.
  - CALC: WIDTH iterations.
  - FIX: sign correction and HI/LO write.
- IDLE with start=1:
  - mult/multu/div/divu: latch operands, op and operand signs; go to CALC with counter = 0.
  - mthi: hi <= din1 at that edge, stay IDLE, busy and done stay 0. mtlo likewise writes lo.
  - op 110/111: ignored.
- Signed ops (mult, div) latch magnitudes |din1| and |din2| in WIDTH+1 bits, so -2^(WIDTH-1) is exact. Unsigned ops latch the raw operands.
- CALC, multiply: radix-2 shift-add, 2·WIDTH-bit product register, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first. The partial remainder is WIDTH+1 bits.
- CALC to FIX when counter reaches WIDTH-1; the counter increments every CALC cycle.
- FIX then IDLE. At the FIX edge hi/lo are written and done goes to 1 for the next cycle.
  - Multiply: if signs differ, {hi,lo} = two's-complement negation of the 2·WIDTH-bit magnitude product.
  - Divide: the quotient is negated if the signs differ. The remainder takes the sign of the dividend. Results wrap mod 2^WIDTH, so -2^(WIDTH-1) / -1 gives lo = 2^(WIDTH-1), hi = 0.
  - Divide by zero (either signedness): hi = latched din1 as supplied (not the magnitude), lo = all ones. Latency is unchanged.
- start while busy=1 is ignored; operands are not re-latched. mthi/mtlo while busy are also ignored; control must stall them.
- flush=1 in any state: return to IDLE at that edge. hi/lo are not modified, done=0. flush has priority over start in the same cycle.
- rst has priority over flush and start.
- hi/lo change only at a FIX edge, an mthi/mtlo edge, or reset.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
- busy is registered: busy=1 exactly while the state is CALC or FIX.
- start accepted at edge E0: busy=1 from after E0 until after edge E0+WIDTH+1. hi/lo take new values after E0+WIDTH+1, and done=1 for the single cycle following it.
- Total latency from start edge to result visible is WIDTH+1 cycles (33 for WIDTH=32).
- Back-to-back: start may be accepted in the done cycle, since busy=0 there.
- mthi/mtlo: zero-wait; the value is visible on hi/lo in the cycle after the start edge.
- No combinational path from inputs to any output.

## Test plan
- WIDTH=32, mult din1=0xFFFFFFFF, din2=0x00000002 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulse for one cycle. Same operands with multu -> hi=0x00000001, lo=0xFFFFFFFE.
- div din1=0xFFFFFFF9 (-7), din2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu din1=0x80000000, din2=0xFFFFFFFF -> lo=0, hi=0x80000000. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu din1=0x00001234, din2=0 -> hi=0x00001234, lo=0xFFFFFFFF, still 33-cycle latency.
- mtlo 0xABCD0000 then mthi 0x12345678 on consecutive cycles -> lo then hi update one cycle each, busy never asserted. mthi during a running mult -> hi unchanged until the mult result lands.
- Start mult 5×3, assert flush on cycle 10 -> busy=0 next cycle, hi/lo keep their prior values, no done. A start in the same cycle as flush is not accepted.
- Assert rst mid-divide -> hi=lo=0, busy=done=0 next cycle. A subsequent multu 0x12345678×0x10 -> hi=0x00000001, lo=0x23456780.
